// File: rtl/insn_queue.sv
// Instruction queue between fetch and decode.
// Holds up to DEPTH {pc, insn} pairs in FIFO order with valid/ready on both sides.
// Full/empty are resolved from the occupancy count, never from pointer equality.
// A flush discards every entry; the head stays visible during the flush cycle itself.
module insn_queue #(
    parameter int          DWIDTH   = 32,
    parameter int          AWIDTH   = 32,
    parameter int          DEPTH    = 4,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [AWIDTH-1:0]          in_pc_i,
    input  logic [DWIDTH-1:0]          in_insn_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [AWIDTH-1:0]          out_pc_o,
    output logic [DWIDTH-1:0]          out_insn_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    // Entry storage; deliberately not reset, only pointers and count are.
    logic [AWIDTH-1:0] pc_mem   [DEPTH];
    logic [DWIDTH-1:0] insn_mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic push;
    logic pop;

    // Handshake flags and head presentation, all derived from the registered count.
    always_comb begin
        in_ready_o  = (count_q != CW'(DEPTH));
        out_valid_o = (count_q != '0);
        push        = in_valid_i & in_ready_o;
        pop         = out_valid_o & out_ready_i;
        count_o     = count_q;
        out_pc_o    = '0;
        out_insn_o  = DWIDTH'(NOP_INSN);
        if (out_valid_o) begin
            out_pc_o   = pc_mem[rd_ptr_q];
            out_insn_o = insn_mem[rd_ptr_q];
        end
    end

    // Next-state for pointers and count; flush overrides any push or pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry write on an accepted push; a push coinciding with flush is dropped.
    always_ff @(posedge clk) begin
        if (push && !flush_i) begin
            pc_mem[wr_ptr_q]   <= in_pc_i;
            insn_mem[wr_ptr_q] <= in_insn_i;
        end
    end

endmodule
